// File: rtl/reg_wb_arbiter.sv
// Two-requester register-file writeback arbiter with round-robin fairness on contention.
// Optional pending-write scoreboard is enabled by defining REG_SCOREBOARD_EN.
module reg_wb_arbiter #(
  parameter int unsigned START_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
`ifdef REG_SCOREBOARD_EN
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
`endif
  output logic        RegWrite,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  // last_b = 1 means B holds the most recent grant, so A wins the next contention
  logic last_b;
  logic a_grant_c;
  logic b_grant_c;

  always_comb begin
    a_grant_c = 1'b0;
    b_grant_c = 1'b0;
    if (!rst) begin
      if (a_valid && (!b_valid || last_b)) begin
        a_grant_c = 1'b1;
      end else if (b_valid) begin
        b_grant_c = 1'b1;
      end
    end
  end

  assign a_ready = a_grant_c;
  assign b_ready = b_grant_c;

  // Writeback register stage; writes to x0 are accepted but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite <= 1'b0;
      rd_addr  <= REG_W'(0);
      rd_data  <= DATA_W'(0);
      last_b   <= 1'(START_PRIO == 0);
    end else begin
      RegWrite <= 1'b0;
      if (a_grant_c) begin
        RegWrite <= (a_rd != REG_W'(0));
        rd_addr  <= a_rd;
        rd_data  <= a_data;
        last_b   <= 1'b0;
      end else if (b_grant_c) begin
        RegWrite <= (b_rd != REG_W'(0));
        rd_addr  <= b_rd;
        rd_data  <= b_data;
        last_b   <= 1'b1;
      end
    end
  end

`ifdef REG_SCOREBOARD_EN
  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_c;
  logic [NREG-1:0] clr_c;

  always_comb begin
    set_c = NREG'(0);
    clr_c = NREG'(0);
    if (rsv_valid && (rsv_rd != REG_W'(0))) begin
      set_c = NREG'(1) << rsv_rd;
    end
    if (RegWrite) begin
      clr_c = NREG'(1) << rd_addr;
    end
  end

  // Set wins over clear so a re-reservation in the retire cycle stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= NREG'(0);
    end else begin
      pending <= (pending & ~clr_c) | set_c;
    end
  end

  assign rs1_busy = (chk_rs1 != REG_W'(0)) && pending[chk_rs1];
  assign rs2_busy = (chk_rs2 != REG_W'(0)) && pending[chk_rs2];
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_reg_wb_arbiter;

  localparam int unsigned START_PRIO = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        regwrite;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef REG_SCOREBOARD_EN
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_rd = '0;
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: who was granted last (0 = A, 1 = B) and the expected write port
  int          last_win;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.START_PRIO(START_PRIO)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
`ifdef REG_SCOREBOARD_EN
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`endif
    .RegWrite(regwrite), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Winner this cycle: -1 none, 0 A, 1 B; contention goes to whoever was not granted last
  function automatic int mdl_winner();
    if (rst || (!a_valid && !b_valid)) return -1;
    if (a_valid && !b_valid) return 0;
    if (b_valid && !a_valid) return 1;
    return 1 - last_win;
  endfunction

  task automatic model_edge(input int w);
    if (rst) begin
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      last_win = 1 - int'(START_PRIO);
    end else if (w == 0) begin
      exp_we = (a_rd != 5'd0); exp_addr = a_rd; exp_data = a_data; last_win = 0;
    end else if (w == 1) begin
      exp_we = (b_rd != 5'd0); exp_addr = b_rd; exp_data = b_data; last_win = 1;
    end else begin
      exp_we = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge(mdl_winner());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd4; b_rd = 5'd8;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready);
    end
    model_edge(mdl_winner());
    @(posedge clk); #1;
    checks++;
    if (regwrite !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got we=%b addr=%0d data=%h expected 0 0 0", regwrite, rd_addr, rd_data);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_contention();
    test_reset();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h0000_00A5;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h0000_00B6;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL contend_first_grant: got a=%b b=%b expected 1 0", a_ready, b_ready);
    end
    model_edge(mdl_winner());
    @(posedge clk); #1;
    checks++;
    if (regwrite !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h0000_00A5) begin
      errors++; $display("FAIL contend_write_x5: got we=%b addr=%0d data=%h expected 1 5 a5", regwrite, rd_addr, rd_data);
    end
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL contend_second_grant: got a=%b b=%b expected 0 1", a_ready, b_ready);
    end
    model_edge(mdl_winner());
    @(posedge clk); #1;
    checks++;
    if (regwrite !== 1'b1 || rd_addr !== 5'd6 || rd_data !== 32'h0000_00B6) begin
      errors++; $display("FAIL contend_write_x6: got we=%b addr=%0d data=%h expected 1 6 b6", regwrite, rd_addr, rd_data);
    end
    b_valid = 1'b0;
    tick();
    checks++;
    if (regwrite !== 1'b0 || rd_addr !== 5'd6 || rd_data !== 32'h0000_00B6) begin
      errors++; $display("FAIL idle_hold: got we=%b addr=%0d data=%h expected 0 6 b6", regwrite, rd_addr, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 32'h11 * 32'(i + 1);
      b_valid = 1'b1; b_rd = 5'd10; b_data = d;
      @(negedge clk);
      checks++;
      if (b_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, b_ready);
      end
      model_edge(mdl_winner());
      @(posedge clk); #1;
      checks++;
      if (regwrite !== 1'b1 || rd_addr !== 5'd10 || rd_data !== d) begin
        errors++; $display("FAIL b2b_write_%0d: got we=%b addr=%0d data=%h expected 1 10 %h", i, regwrite, rd_addr, rd_data, d);
      end
    end
    b_valid = 1'b0;
    tick();
    checks++;
    if (regwrite !== 1'b0 || rd_data !== 32'h33) begin
      errors++; $display("FAIL b2b_end: got we=%b data=%h expected 0 33", regwrite, rd_data);
    end
  endtask

  task automatic test_rd_zero();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL rd0_ready: got %b expected 1", a_ready);
    end
    model_edge(mdl_winner());
    @(posedge clk); #1;
    checks++;
    if (regwrite !== 1'b0) begin
      errors++; $display("FAIL rd0_no_write: got %b expected 0", regwrite);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_same_rd();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h55;
    tick();
    a_rd = 5'd7; a_data = 32'h1;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h2;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL same_rd_grant_b: got a=%b b=%b expected 0 1", a_ready, b_ready);
    end
    model_edge(mdl_winner());
    @(posedge clk); #1;
    checks++;
    if (regwrite !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h2) begin
      errors++; $display("FAIL same_rd_first: got we=%b addr=%0d data=%h expected 1 7 2", regwrite, rd_addr, rd_data);
    end
    b_valid = 1'b0;
    tick();
    checks++;
    if (regwrite !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h1) begin
      errors++; $display("FAIL same_rd_final: got we=%b addr=%0d data=%h expected 1 7 1", regwrite, rd_addr, rd_data);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_reset_handshake();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3333;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin
      errors++; $display("FAIL rst_hs_ready: got %b expected 0", a_ready);
    end
    model_edge(mdl_winner());
    @(posedge clk); #1;
    checks++;
    if (regwrite !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
      errors++; $display("FAIL rst_hs_discard: got we=%b addr=%0d data=%h expected 0 0 0", regwrite, rd_addr, rd_data);
    end
    rst = 1'b0; a_valid = 1'b0;
  endtask

  task automatic test_random();
    int  w;
    bit  a_taken = 1'b1;
    bit  b_taken = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!a_valid || a_taken) begin
        a_valid = 1'($urandom_range(0, 1)); a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
      end
      if (!b_valid || b_taken) begin
        b_valid = 1'($urandom_range(0, 1)); b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
      end
      @(negedge clk);
      w = mdl_winner();
      checks++;
      if (a_ready !== (w == 0) || b_ready !== (w == 1)) begin
        errors++; $display("FAIL rand_ready_%0d: got a=%b b=%b expected winner %0d", i, a_ready, b_ready, w);
      end
      model_edge(w);
      @(posedge clk); #1;
      checks++;
      if (regwrite !== exp_we || rd_addr !== exp_addr || rd_data !== exp_data) begin
        errors++; $display("FAIL rand_out_%0d: got we=%b addr=%0d data=%h expected %b %0d %h",
                           i, regwrite, rd_addr, rd_data, exp_we, exp_addr, exp_data);
      end
      a_taken = (w == 0);
      b_taken = (w == 1);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

`ifdef REG_SCOREBOARD_EN
  task automatic test_scoreboard();
    test_reset();
    rsv_valid = 1'b1; rsv_rd = 5'd9;
    tick();
    rsv_valid = 1'b0; chk_rs1 = 5'd9; chk_rs2 = 5'd0;
    #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL sb_reserved: got rs1=%b rs2=%b expected 1 0", rs1_busy, rs2_busy);
    end
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h9;
    tick();
    a_valid = 1'b0; rsv_valid = 1'b1; rsv_rd = 5'd9;
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++; $display("FAIL sb_busy_in_write: got %b expected 1", rs1_busy);
    end
    tick();
    rsv_valid = 1'b0;
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++; $display("FAIL sb_rereserve: got %b expected 1", rs1_busy);
    end
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++; $display("FAIL sb_cleared: got %b expected 0", rs1_busy);
    end
  endtask
`endif

  initial begin
    last_win = 1 - int'(START_PRIO);
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    test_reset();
    test_contention();
    test_back_to_back();
    test_rd_zero();
    test_same_rd();
    test_reset_handshake();
    test_random();
`ifdef REG_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter START_PRIO, default 0, selecting the requester (0 = A, 1 = B) that wins the first contended cycle after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port a_valid  input  1  requester A (ALU writeback) holds a write request.
REQ-005 SHALL have port a_rd  input  5  requester A destination register.
REQ-006 SHALL have port a_data  input  32  requester A write data.
REQ-007 SHALL have port a_ready  output  1  requester A request accepted this cycle (combinational).
REQ-008 SHALL have ports b_valid / b_rd / b_data / b_ready with the same widths and meaning for requester B (load writeback).
REQ-009 SHALL have port RegWrite  output  1  register-file write enable, registered.
REQ-010 SHALL have port rd_addr  output  5  register-file write address, registered.
REQ-011 SHALL have port rd_data  output  32  register-file write data, registered.
REQ-012 SHALL, when REG_SCOREBOARD_EN is defined, add ports rsv_valid (input, 1), rsv_rd (input, 5), chk_rs1 (input, 5), chk_rs2 (input, 5), rs1_busy (output, 1) and rs2_busy (output, 1).

Function
REQ-013 SHALL perform a handshake for a requester in a cycle when that requester's valid and ready are both 1; at most one ready SHALL be 1 per cycle.
REQ-014 SHALL drive ready = 1 for the only valid requester when exactly one requester is valid, and drive both readies to 0 when neither is valid.
REQ-015 SHALL, when both requesters are valid, grant the requester that was not granted last; the last-grant pointer SHALL update only on a handshake.
REQ-016 SHALL, for a handshake in cycle N, drive RegWrite/rd_addr/rd_data in cycle N+1 with the granted rd and data; RegWrite SHALL be 1 for exactly that one cycle per handshake.
REQ-017 SHALL drive RegWrite = 0 in cycle N+1 when there is no handshake in cycle N; rd_addr and rd_data SHALL hold their previous values.
REQ-018 SHALL accept a request with rd = 0 (ready = 1) but drive RegWrite = 0 for the corresponding cycle.
REQ-019 SHALL, when both requesters target the same rd, issue the writes in grant order; the register holds the later-granted data.
REQ-020 SHALL require a requester whose valid = 1 and ready = 0 to hold its rd and data stable; the arbiter stores no request data.
REQ-021 SHALL allow back-to-back handshakes every cycle (throughput one write per cycle) with no bubble.

Reset
REQ-022 SHALL, while rst = 1, set RegWrite = 0, rd_addr = 0, rd_data = 0 and the last-grant pointer so that START_PRIO wins the next contended cycle.
REQ-023 SHALL, when rst is asserted in a cycle with a handshake, discard that write: RegWrite = 0 in the following cycle.
REQ-024 SHALL force a_ready = b_ready = 0 while rst = 1.
REQ-025 SHALL, when REG_SCOREBOARD_EN is defined, clear all 32 pending bits while rst = 1.

Configuration
REQ-026 SHALL, with REG_SCOREBOARD_EN defined, keep a 32-bit pending mask: a clock edge with rsv_valid = 1 and rsv_rd != 0 SETS bit rsv_rd.
REQ-027 SHALL, with REG_SCOREBOARD_EN defined, CLEAR the pending bit for rd_addr on the edge ending a cycle with RegWrite = 1; a simultaneous set and clear of the same bit SHALL leave it set.
REQ-028 SHALL, with REG_SCOREBOARD_EN defined, drive rsN_busy = pending[chk_rsN] combinationally, and drive it as 0 when chk_rsN = 0.
REQ-029 SHALL, without REG_SCOREBOARD_EN, omit the scoreboard ports and storage; arbitration behaviour SHALL be identical in both builds.

Verification
REQ-030 SHALL cover: after reset, a_valid = b_valid = 1 with a_rd = 5, b_rd = 6 -> with START_PRIO = 0, A is granted, then B; RegWrite pulses on x5 then x6 on consecutive cycles.
REQ-031 SHALL cover: b_valid alone held for 3 cycles, with b_rd = 10 and data 0x11, 0x22, 0x33 -> three consecutive RegWrite pulses to x10, ending with 0x33.
REQ-032 SHALL cover: a_valid = 1 with a_rd = 0 and a_data = 0xDEADBEEF -> a_ready = 1 and RegWrite stays 0.
REQ-033 SHALL cover: both requesters targeting rd = 7 with A = 0x1 and B = 0x2 after last grant = A -> B is written first, then A; the final x7 = 0x1.
REQ-034 SHALL cover: rst asserted in the same cycle as a handshake for rd = 3 -> no RegWrite in the next cycle; all outputs are 0.
REQ-035 SHALL cover (REG_SCOREBOARD_EN): reserve x9, set chk_rs1 = 9 -> rs1_busy = 1 until the cycle after the RegWrite pulse to x9; re-reserving x9 in the clear cycle keeps it busy.
